// File: rtl/audio_sfx_arbiter.sv
// Fixed-priority arbiter and square-wave tone sequencer for four sound-effect requesters.
// One owner plays at a time; lower index preempts; every completed effect is followed by a silence gap.
module audio_sfx_arbiter #(
  parameter logic [31:0] AMPL       = 32'd100000000,
  parameter int          HP_W       = 20,
  parameter int          DUR_W      = 28,
  parameter int          GAP_CYCLES = 500000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [3:0]          req,
  input  logic [4*HP_W-1:0]   req_half_period,
  input  logic [4*DUR_W-1:0]  req_duration,
  input  logic                mute,
  input  logic                audio_out_allowed,
  output logic [3:0]          grant,
  output logic [3:0]          active,
  output logic [3:0]          done,
  output logic [3:0]          preempt,
  output logic [31:0]         left_channel_audio_out,
  output logic [31:0]         right_channel_audio_out,
  output logic                write_audio_out
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  localparam logic signed [31:0] POS = AMPL;
  localparam logic signed [31:0] NEG = -POS;

  state_t             r_state;
  logic [1:0]         r_owner;
  logic [HP_W-1:0]    r_hp;
  logic [DUR_W-1:0]   r_dur;
  logic [DUR_W-1:0]   r_dur_cnt;
  logic [HP_W-1:0]    r_half_cnt;
  logic [31:0]        r_gap_cnt;
  logic               r_sign;
  logic [3:0]         r_grant;
  logic [3:0]         r_active;
  logic [3:0]         r_done;
  logic [3:0]         r_preempt;
  logic signed [31:0] r_sample;

  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic signed [31:0] tone_sample(input logic sign);
    return sign ? NEG : POS;
  endfunction

  logic [3:0]       w_hi;
  logic [3:0]       w_cand;
  logic [1:0]       w_sel;
  logic [HP_W-1:0]  w_sel_hp;
  logic [DUR_W-1:0] w_sel_dur_raw;
  logic [DUR_W-1:0] w_sel_dur;
  logic             w_dur_end;
  logic             w_half_end;
  logic             w_start;

  // In PLAY only requesters above the current owner compete; in IDLE everyone does.
  assign w_hi          = req & ((4'b0001 << r_owner) - 4'b0001);
  assign w_cand        = (r_state == PLAY) ? w_hi : req;
  assign w_sel         = lowest_idx(w_cand);
  assign w_sel_hp      = req_half_period[w_sel*HP_W +: HP_W];
  assign w_sel_dur_raw = req_duration[w_sel*DUR_W +: DUR_W];
  assign w_sel_dur     = (w_sel_dur_raw == '0) ? DUR_W'(1) : w_sel_dur_raw;
  assign w_dur_end     = (r_dur_cnt == r_dur - DUR_W'(1));
  assign w_half_end    = (r_hp != '0) && (r_half_cnt == r_hp - HP_W'(1));
  // Completion beats a same-edge preemption, so the end-of-effect test gates the PLAY start.
  assign w_start       = !mute && (((r_state == IDLE) && (req != 4'b0000)) ||
                                   ((r_state == PLAY) && !w_dur_end && (w_hi != 4'b0000)));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_owner    <= 2'd0;
      r_hp       <= '0;
      r_dur      <= '0;
      r_dur_cnt  <= '0;
      r_half_cnt <= '0;
      r_gap_cnt  <= '0;
      r_sign     <= 1'b0;
      r_grant    <= 4'b0000;
      r_active   <= 4'b0000;
      r_done     <= 4'b0000;
      r_preempt  <= 4'b0000;
      r_sample   <= '0;
    end else begin
      r_grant   <= 4'b0000;
      r_done    <= 4'b0000;
      r_preempt <= 4'b0000;
      if (mute) begin
        r_state  <= IDLE;
        r_active <= 4'b0000;
        r_sample <= '0;
      end else if (w_start) begin
        if (r_state == PLAY) r_preempt <= r_active;
        r_state    <= PLAY;
        r_owner    <= w_sel;
        r_hp       <= w_sel_hp;
        r_dur      <= w_sel_dur;
        r_dur_cnt  <= '0;
        r_half_cnt <= '0;
        r_sign     <= 1'b0;
        r_grant    <= 4'b0001 << w_sel;
        r_active   <= 4'b0001 << w_sel;
        r_sample   <= (w_sel_hp != '0) ? POS : '0;
      end else begin
        case (r_state)
          PLAY: begin
            if (w_dur_end) begin
              r_state   <= GAP;
              r_done    <= r_active;
              r_active  <= 4'b0000;
              r_gap_cnt <= '0;
              r_sample  <= '0;
            end else begin
              r_dur_cnt <= r_dur_cnt + DUR_W'(1);
              if (w_half_end) begin
                r_half_cnt <= '0;
                r_sign     <= ~r_sign;
                r_sample   <= tone_sample(~r_sign);
              end else if (r_hp != '0) begin
                r_half_cnt <= r_half_cnt + HP_W'(1);
              end
            end
          end
          GAP: begin
            r_sample <= '0;
            if (r_gap_cnt == 32'(GAP_CYCLES - 1)) r_state <= IDLE;
            else r_gap_cnt <= r_gap_cnt + 32'd1;
          end
          default: r_sample <= '0;
        endcase
      end
    end
  end

  assign grant                   = r_grant;
  assign active                  = r_active;
  assign done                    = r_done;
  assign preempt                 = r_preempt;
  assign left_channel_audio_out  = r_sample;
  assign right_channel_audio_out = r_sample;
  assign write_audio_out         = audio_out_allowed;

endmodule

// File: tb/tb_audio_sfx_arbiter.sv
// Randomized bench for audio_sfx_arbiter against an elapsed-time reference model.
module tb_audio_sfx_arbiter;
  localparam int HP_W = 20;
  localparam int DUR_W = 28;
  localparam int GAP = 4;
  localparam logic signed [31:0] AMP = 32'sd100000000;

  logic              clk, rst;
  logic [3:0]        req;
  logic [4*HP_W-1:0] rhp;
  logic [4*DUR_W-1:0] rdur;
  logic              mute, allowed;
  logic [3:0]        grant, active, done, preempt;
  logic [31:0]       left_s, right_s;
  logic              wr;

  audio_sfx_arbiter #(.AMPL(32'd100000000), .HP_W(HP_W), .DUR_W(DUR_W), .GAP_CYCLES(GAP)) dut (
    .CLOCK_50(clk), .reset(rst), .req(req), .req_half_period(rhp), .req_duration(rdur),
    .mute(mute), .audio_out_allowed(allowed), .grant(grant), .active(active), .done(done),
    .preempt(preempt), .left_channel_audio_out(left_s), .right_channel_audio_out(right_s),
    .write_audio_out(wr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner (-1 = none), cycles elapsed since grant, gap cycles remaining.
  int m_owner = -1, m_t = 0, m_hp = 0, m_dur = 1, m_gap = 0;
  logic [3:0] e_grant = 0, e_done = 0, e_pre = 0;
  bit drop_on_grant = 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_par(input int i, input int hp, input int dur);
    rhp[i*HP_W +: HP_W] = HP_W'(hp);
    rdur[i*DUR_W +: DUR_W] = DUR_W'(dur);
  endtask

  task automatic model_take(input int j);
    m_owner = j;
    m_t = 0;
    m_hp = int'(rhp[j*HP_W +: HP_W]);
    m_dur = int'(rdur[j*DUR_W +: DUR_W]);
    if (m_dur == 0) m_dur = 1;
    e_grant[j] = 1'b1;
  endtask

  task automatic model_edge();
    int j;
    e_grant = 0; e_done = 0; e_pre = 0;
    if (mute) begin
      m_owner = -1; m_gap = 0;
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (m_owner < 0) begin
      j = -1;
      for (int i = 3; i >= 0; i--) if (req[i]) j = i;
      if (j >= 0) model_take(j);
    end else if (m_t + 1 >= m_dur) begin
      e_done[m_owner] = 1'b1;
      m_owner = -1;
      m_gap = GAP;
    end else begin
      j = -1;
      for (int i = 3; i >= 0; i--) if (req[i] && i < m_owner) j = i;
      if (j >= 0) begin
        e_pre[m_owner] = 1'b1;
        model_take(j);
      end else m_t++;
    end
  endtask

  function automatic logic [31:0] exp_sample();
    if (m_owner < 0 || m_hp == 0) return 32'd0;
    return ((m_t / m_hp) % 2 == 1) ? -AMP : AMP;
  endfunction

  task automatic check_outputs();
    logic [3:0] ea;
    ea = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    chk("grant", 32'(grant), 32'(e_grant));
    chk("active", 32'(active), 32'(ea));
    chk("done", 32'(done), 32'(e_done));
    chk("preempt", 32'(preempt), 32'(e_pre));
    chk("left", left_s, exp_sample());
    chk("right", right_s, exp_sample());
    chk("write", 32'(wr), 32'(allowed));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    if (drop_on_grant) req = req & ~e_grant;
    allowed = 1'($urandom_range(0, 1));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 0; req = 0; rhp = 0; rdur = 0; mute = 0; allowed = 0;
    #1 rst = 1;
    #1;
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_left", left_s, 32'd0);
    chk("rst_write", 32'(wr), 32'(allowed));
    @(posedge clk); @(posedge clk);
    #2 rst = 0;
    run(2);

    // Basic tone: hp=3, dur=10, then gap.
    set_par(2, 3, 10); req[2] = 1; run(20);
    // Simultaneous requests: lower index first, the other after the gap.
    set_par(1, 2, 5); set_par(3, 4, 6); req[1] = 1; req[3] = 1; run(25);
    // Preemption of a long effect.
    set_par(3, 5, 100); set_par(0, 2, 7); req[3] = 1; run(21);
    req[0] = 1; run(20);
    req = 0; run(10);
    // Mute mid-play, then held mute with a pending request.
    set_par(2, 3, 40); req[2] = 1; run(6);
    mute = 1; run(3);
    set_par(1, 1, 5); req[1] = 1; run(50);
    mute = 0; run(20);
    // Rest effect and zero duration.
    set_par(0, 0, 8); req[0] = 1; run(15);
    set_par(3, 1, 0); req[3] = 1; run(10);
    // Held request is re-granted after its own gap.
    drop_on_grant = 0; set_par(2, 2, 3); req = 4'b0100; run(20);
    req = 0; drop_on_grant = 1; run(8);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) drop_on_grant = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        int b;
        b = $urandom_range(0, 3);
        set_par(b, $urandom_range(0, 6), $urandom_range(0, 30));
        req[b] = 1'b1;
      end
      if (!drop_on_grant && $urandom_range(0, 20) == 0) req[$urandom_range(0, 3)] = 1'b0;
      if (!mute && $urandom_range(0, 120) == 0) mute = 1;
      else if (mute && $urandom_range(0, 7) == 0) mute = 0;
      step();
    end

    // Asynchronous reset between edges while playing.
    mute = 0; req = 0; drop_on_grant = 1; run(GAP + 2);
    set_par(1, 3, 50); req[1] = 1; run(5);
    chk("pre_rst_active", 32'(active), 32'b0010);
    #2 rst = 1; allowed = 1;
    #1;
    chk("async_active", 32'(active), 32'd0);
    chk("async_left", left_s, 32'd0);
    chk("async_right", right_s, 32'd0);
    chk("async_write", 32'(wr), 32'd1);
    m_owner = -1; m_gap = 0; e_grant = 0; e_done = 0; e_pre = 0;
    req = 4'b0100; set_par(2, 2, 6);
    @(posedge clk);
    #3 rst = 0;
    run(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
